// File: rtl/udp_tx_packetizer.sv
// Multi-channel UDP transmit front end: round-robin grant over CH_N AXI-Stream
// sources, frame buffering with byte counting, one UDP header, then 8-bit payload.
module udp_tx_packetizer #(
    parameter int DATA_W      = 64,
    parameter int CH_N        = 2,
    parameter int DEPTH_WORDS = 256,
    parameter int MAX_PAYLOAD = 1472
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [CH_N*DATA_W-1:0]     s_axis_tdata,
    input  logic [CH_N*DATA_W/8-1:0]   s_axis_tkeep,
    input  logic [CH_N-1:0]            s_axis_tvalid,
    input  logic [CH_N-1:0]            s_axis_tlast,
    output logic [CH_N-1:0]            s_axis_tready,
    output logic                       m_udp_hdr_valid,
    input  logic                       m_udp_hdr_ready,
    output logic [5:0]                 m_udp_ip_dscp,
    output logic [1:0]                 m_udp_ip_ecn,
    output logic [7:0]                 m_udp_ip_ttl,
    output logic [31:0]                m_udp_ip_source_ip,
    output logic [31:0]                m_udp_ip_dest_ip,
    output logic [15:0]                m_udp_source_port,
    output logic [15:0]                m_udp_dest_port,
    output logic [15:0]                m_udp_length,
    output logic [15:0]                m_udp_checksum,
    output logic [7:0]                 m_udp_payload_axis_tdata,
    output logic                       m_udp_payload_axis_tvalid,
    input  logic                       m_udp_payload_axis_tready,
    output logic                       m_udp_payload_axis_tlast,
    output logic                       m_udp_payload_axis_tuser,
    input  logic [31:0]                local_ip,
    input  logic [31:0]                dest_ip,
    input  logic [15:0]                local_port,
    input  logic [15:0]                dest_port_base,
    output logic                       busy,
    output logic                       drop_pulse,
    output logic [15:0]                drop_count,
    output logic [2:0]                 dbg_state
);
    // Handshakes: a transfer happens on a rising clk edge where valid and ready
    // are both high; valid and its data stay stable until that edge.

    localparam int BYTES = DATA_W / 8;
    localparam int AW    = $clog2(DEPTH_WORDS);
    localparam int CH_W  = (CH_N > 1) ? $clog2(CH_N) : 1;
    localparam int LW    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [AW:0] WORDS_MAX = (AW+1)'(DEPTH_WORDS);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_DROP    = 3'd2,
        S_HDR     = 3'd3,
        S_PAYLOAD = 3'd4
    } state_t;

    state_t              r_state, w_next;
    logic [CH_W-1:0]     r_grant, r_last_grant, w_pick;
    logic                w_any;
    logic [15:0]         r_byte_cnt, r_len, r_rd_byte;
    logic [AW:0]         r_wr_ptr;
    logic [DATA_W-1:0]   r_buf [DEPTH_WORDS];
    logic [31:0]         r_src_ip, r_dst_ip;
    logic [15:0]         r_src_port, r_dst_port;
    logic [7:0]          r_pay_data;
    logic                r_pay_valid, r_pay_last;
    logic                r_drop_pulse;
    logic [15:0]         r_drop_count;

    logic [DATA_W-1:0]   w_tdata;
    logic [BYTES-1:0]    w_tkeep;
    logic                w_tvalid, w_tlast;
    logic [15:0]         w_add;
    logic [16:0]         w_sum;
    logic                w_ovf, w_beat, w_store, w_drop_evt, w_hdr_latch, w_done;
    logic [AW-1:0]       w_rd_idx;
    logic [LW-1:0]       w_lane;
    logic [DATA_W-1:0]   w_rd_word;
    logic [7:0]          w_rd_data;

    function automatic logic [15:0] popcnt(input logic [BYTES-1:0] k);
        logic [15:0] n;
        n = '0;
        for (int i = 0; i < BYTES; i++) n = n + 16'(k[i]);
        return n;
    endfunction

    // Round-robin search starts just after the channel served last.
    always_comb begin
        w_any  = 1'b0;
        w_pick = '0;
        for (int i = 1; i <= CH_N; i++) begin
            if (!w_any && s_axis_tvalid[(int'(r_last_grant) + i) % CH_N]) begin
                w_any  = 1'b1;
                w_pick = CH_W'((int'(r_last_grant) + i) % CH_N);
            end
        end
    end

    assign w_tdata  = s_axis_tdata[int'(r_grant)*DATA_W +: DATA_W];
    assign w_tkeep  = s_axis_tkeep[int'(r_grant)*BYTES +: BYTES];
    assign w_tvalid = s_axis_tvalid[r_grant];
    assign w_tlast  = s_axis_tlast[r_grant];
    assign w_add    = w_tlast ? popcnt(w_tkeep) : 16'(BYTES);
    assign w_sum    = {1'b0, r_byte_cnt} + {1'b0, w_add};
    assign w_ovf    = (w_sum > 17'(MAX_PAYLOAD)) || (r_wr_ptr == WORDS_MAX);

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state and per-cycle events
    always_comb begin
        w_next      = r_state;
        w_beat      = 1'b0;
        w_store     = 1'b0;
        w_drop_evt  = 1'b0;
        w_hdr_latch = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: if (w_any) w_next = S_COLLECT;
            S_COLLECT: begin
                w_beat  = w_tvalid;
                w_store = w_tvalid && !w_ovf;
                if (w_tvalid) begin
                    if (w_ovf) begin
                        w_next     = w_tlast ? S_IDLE : S_DROP;
                        w_drop_evt = w_tlast;
                    end else if (w_tlast) begin
                        if (w_sum == 17'd0) begin
                            w_next     = S_IDLE;
                            w_drop_evt = 1'b1;
                        end else begin
                            w_next      = S_HDR;
                            w_hdr_latch = 1'b1;
                        end
                    end
                end
            end
            S_DROP: if (w_tvalid && w_tlast) begin
                w_next     = S_IDLE;
                w_drop_evt = 1'b1;
            end
            S_HDR: if (m_udp_hdr_ready) w_next = S_PAYLOAD;
            S_PAYLOAD: if (r_pay_valid && r_pay_last && m_udp_payload_axis_tready) begin
                w_next = S_IDLE;
                w_done = 1'b1;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        s_axis_tready = '0;
        if (r_state == S_COLLECT || r_state == S_DROP) s_axis_tready[r_grant] = 1'b1;
        m_udp_hdr_valid = (r_state == S_HDR);
        busy            = (r_state != S_IDLE);
        dbg_state       = r_state;
    end

    always_ff @(posedge clk) begin
        if (w_store) r_buf[r_wr_ptr[AW-1:0]] <= w_tdata;
    end

    // Byte k lives in word k/BYTES, lane k%BYTES, least significant lane first.
    assign w_rd_idx  = AW'(r_rd_byte / 16'(BYTES));
    assign w_lane    = LW'(r_rd_byte % 16'(BYTES));
    assign w_rd_word = r_buf[w_rd_idx];
    assign w_rd_data = w_rd_word[{w_lane, 3'b000} +: 8];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant      <= '0;
            r_last_grant <= CH_W'(CH_N - 1);
            r_byte_cnt   <= '0;
            r_wr_ptr     <= '0;
            r_len        <= '0;
            r_rd_byte    <= '0;
            r_src_ip     <= '0;
            r_dst_ip     <= '0;
            r_src_port   <= '0;
            r_dst_port   <= '0;
            r_pay_data   <= '0;
            r_pay_valid  <= 1'b0;
            r_pay_last   <= 1'b0;
            r_drop_pulse <= 1'b0;
            r_drop_count <= '0;
        end else begin
            r_drop_pulse <= w_drop_evt;
            if (w_drop_evt && r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 16'd1;
            if (r_state == S_IDLE && w_any) begin
                r_grant    <= w_pick;
                r_byte_cnt <= '0;
                r_wr_ptr   <= '0;
            end
            if (w_store) begin
                r_byte_cnt <= w_sum[15:0];
                r_wr_ptr   <= r_wr_ptr + 1'b1;
            end
            if (w_hdr_latch) begin
                r_len      <= w_sum[15:0];
                r_src_ip   <= local_ip;
                r_dst_ip   <= dest_ip;
                r_src_port <= local_port;
                r_dst_port <= dest_port_base + 16'(r_grant);
            end
            if (r_state == S_HDR && m_udp_hdr_ready) begin
                r_rd_byte   <= '0;
                r_pay_valid <= 1'b0;
                r_pay_last  <= 1'b0;
            end
            // Output byte register refills when empty or being consumed.
            if (r_state == S_PAYLOAD && (!r_pay_valid || m_udp_payload_axis_tready)) begin
                if (r_rd_byte != r_len) begin
                    r_pay_data  <= w_rd_data;
                    r_pay_valid <= 1'b1;
                    r_pay_last  <= (r_rd_byte == r_len - 16'd1);
                    r_rd_byte   <= r_rd_byte + 16'd1;
                end else begin
                    r_pay_valid <= 1'b0;
                    r_pay_last  <= 1'b0;
                end
            end
            if (w_done) r_last_grant <= r_grant;
        end
    end

    assign m_udp_ip_dscp             = 6'd0;
    assign m_udp_ip_ecn              = 2'd0;
    assign m_udp_ip_ttl              = 8'd64;
    assign m_udp_ip_source_ip        = r_src_ip;
    assign m_udp_ip_dest_ip          = r_dst_ip;
    assign m_udp_source_port         = r_src_port;
    assign m_udp_dest_port           = r_dst_port;
    assign m_udp_length              = r_len + 16'd8;
    assign m_udp_checksum            = 16'd0;
    assign m_udp_payload_axis_tdata  = r_pay_data;
    assign m_udp_payload_axis_tvalid = r_pay_valid;
    assign m_udp_payload_axis_tlast  = r_pay_last;
    assign m_udp_payload_axis_tuser  = 1'b0;
    assign drop_pulse                = r_drop_pulse;
    assign drop_count                = r_drop_count;

endmodule

// File: tb/tb_udp_tx_packetizer.sv
// Directed bench for udp_tx_packetizer: per-channel frame drivers push expected
// headers/bytes into queues; a negedge monitor pops and compares DUT output.
module tb_udp_tx_packetizer;
    localparam int DATA_W = 64;
    localparam int CH_N   = 2;
    localparam logic [31:0] LOCAL_IP  = 32'hC0A8_0001;
    localparam logic [31:0] DEST_IP   = 32'hC0A8_0002;
    localparam logic [15:0] LOCAL_PT  = 16'h1234;
    localparam logic [15:0] PORT_BASE = 16'hFFFF;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst = 1'b1;

    logic [DATA_W-1:0] ch_data  [CH_N];
    logic [7:0]        ch_keep  [CH_N];
    logic              ch_valid [CH_N];
    logic              ch_last  [CH_N];

    logic [CH_N*DATA_W-1:0]   s_axis_tdata;
    logic [CH_N*DATA_W/8-1:0] s_axis_tkeep;
    logic [CH_N-1:0]          s_axis_tvalid, s_axis_tlast, s_axis_tready;
    logic        m_udp_hdr_valid;
    logic        m_udp_hdr_ready = 1'b1;
    logic [5:0]  m_udp_ip_dscp;
    logic [1:0]  m_udp_ip_ecn;
    logic [7:0]  m_udp_ip_ttl;
    logic [31:0] m_udp_ip_source_ip, m_udp_ip_dest_ip;
    logic [15:0] m_udp_source_port, m_udp_dest_port, m_udp_length, m_udp_checksum;
    logic [7:0]  m_udp_payload_axis_tdata;
    logic        m_udp_payload_axis_tvalid, m_udp_payload_axis_tlast, m_udp_payload_axis_tuser;
    logic        m_udp_payload_axis_tready = 1'b1;
    logic        busy, drop_pulse;
    logic [15:0] drop_count;
    logic [2:0]  dbg_state;

    always_comb begin
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tvalid = '0;
        s_axis_tlast  = '0;
        for (int c = 0; c < CH_N; c++) begin
            s_axis_tdata[c*DATA_W +: DATA_W] = ch_data[c];
            s_axis_tkeep[c*8 +: 8]           = ch_keep[c];
            s_axis_tvalid[c]                 = ch_valid[c];
            s_axis_tlast[c]                  = ch_last[c];
        end
    end

    udp_tx_packetizer #(.DATA_W(DATA_W), .CH_N(CH_N), .DEPTH_WORDS(256), .MAX_PAYLOAD(1472)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .m_udp_hdr_valid(m_udp_hdr_valid), .m_udp_hdr_ready(m_udp_hdr_ready),
        .m_udp_ip_dscp(m_udp_ip_dscp), .m_udp_ip_ecn(m_udp_ip_ecn), .m_udp_ip_ttl(m_udp_ip_ttl),
        .m_udp_ip_source_ip(m_udp_ip_source_ip), .m_udp_ip_dest_ip(m_udp_ip_dest_ip),
        .m_udp_source_port(m_udp_source_port), .m_udp_dest_port(m_udp_dest_port),
        .m_udp_length(m_udp_length), .m_udp_checksum(m_udp_checksum),
        .m_udp_payload_axis_tdata(m_udp_payload_axis_tdata),
        .m_udp_payload_axis_tvalid(m_udp_payload_axis_tvalid),
        .m_udp_payload_axis_tready(m_udp_payload_axis_tready),
        .m_udp_payload_axis_tlast(m_udp_payload_axis_tlast),
        .m_udp_payload_axis_tuser(m_udp_payload_axis_tuser),
        .local_ip(LOCAL_IP), .dest_ip(DEST_IP), .local_port(LOCAL_PT), .dest_port_base(PORT_BASE),
        .busy(busy), .drop_pulse(drop_pulse), .drop_count(drop_count), .dbg_state(dbg_state)
    );

    int total = 0;
    int bad = 0;
    int pulses = 0;
    int cyc = 0;
    bit pay_toggle = 1'b0;
    bit hold_pend = 1'b0;
    logic [8:0]  held;
    logic [31:0] exp_hdr_q [$];
    logic [8:0]  exp_byte_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s actual=missing required=event", name);
    endtask

    // Push the header and every payload byte of a frame whose byte i is base+i.
    task automatic expect_frame(input int len, input logic [15:0] dport, input int base);
        exp_hdr_q.push_back({16'(len + 8), dport});
        for (int i = 0; i < len; i++) exp_byte_q.push_back({(i == len - 1), 8'(base + i)});
    endtask

    // Called at a negedge; presents beats 0..stop_at-1 of an n-beat frame.
    task automatic send_beats(input int c, input int n, input logic [7:0] last_keep,
                              input int base, input int stop_at);
        logic [63:0] d;
        int w;
        for (int b = 0; b < stop_at; b++) begin
            for (int j = 0; j < 8; j++) d[8*j +: 8] = 8'(base + 8*b + j);
            ch_data[c]  = d;
            ch_keep[c]  = (b == n - 1) ? last_keep : 8'hFF;
            ch_last[c]  = (b == n - 1);
            ch_valid[c] = 1'b1;
            w = 0;
            while (!s_axis_tready[c] && w < 3000) begin
                @(negedge clk);
                w++;
            end
            if (w >= 3000) fail_now("beat_timeout");
            @(negedge clk);
        end
        if (stop_at == n) begin
            ch_valid[c] = 1'b0;
            ch_last[c]  = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || exp_hdr_q.size() != 0 || exp_byte_q.size() != 0) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 4000) fail_now("idle_timeout");
        repeat (2) @(negedge clk);
    endtask

    // Monitor: sets the sink readies for the coming edge, then checks transfers.
    initial forever begin
        @(negedge clk);
        cyc++;
        m_udp_hdr_ready = (cyc % 3 != 1);
        m_udp_payload_axis_tready = pay_toggle ? (cyc % 2 == 0) : 1'b1;
        if (!rst) begin
            if (hold_pend && m_udp_payload_axis_tvalid)
                check("stall_hold", {m_udp_payload_axis_tlast, m_udp_payload_axis_tdata}, held);
            hold_pend = m_udp_payload_axis_tvalid && !m_udp_payload_axis_tready;
            held = {m_udp_payload_axis_tlast, m_udp_payload_axis_tdata};
            if (m_udp_hdr_valid && m_udp_hdr_ready) begin
                if (exp_hdr_q.size() == 0) fail_now("unexpected_hdr");
                else begin
                    check("hdr_len_port", {m_udp_length, m_udp_dest_port}, exp_hdr_q.pop_front());
                    check("hdr_ip", {m_udp_ip_source_ip, m_udp_ip_dest_ip}, {LOCAL_IP, DEST_IP});
                    check("hdr_misc", {m_udp_ip_dscp, m_udp_ip_ecn, m_udp_ip_ttl, m_udp_checksum,
                                       m_udp_source_port}, {6'd0, 2'd0, 8'd64, 16'd0, LOCAL_PT});
                end
            end
            if (m_udp_payload_axis_tvalid && m_udp_payload_axis_tready) begin
                if (exp_byte_q.size() == 0) fail_now("unexpected_byte");
                else check("payload", {m_udp_payload_axis_tuser, m_udp_payload_axis_tlast,
                                       m_udp_payload_axis_tdata}, {1'b0, exp_byte_q.pop_front()});
            end
            if (drop_pulse) pulses++;
        end else begin
            hold_pend = 1'b0;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        for (int c = 0; c < CH_N; c++) begin
            ch_data[c] = '0; ch_keep[c] = '0; ch_valid[c] = 1'b0; ch_last[c] = 1'b0;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ready", {30'd0, s_axis_tready}, 32'd0);
        check("rst_out", {m_udp_hdr_valid, m_udp_payload_axis_tvalid, m_udp_payload_axis_tlast,
                          busy, drop_pulse}, 5'd0);
        check("rst_drop_count", drop_count, 16'd0);
        check("rst_state", dbg_state, 3'd0);
        rst = 1'b0;
        @(negedge clk);

        // 3 beats, last keep 0x0F: 20 bytes, length 28, channel 0 first after reset
        expect_frame(20, PORT_BASE, 8'h00);
        send_beats(0, 3, 8'h0F, 8'h00, 3);
        wait_idle();

        // Both channels continuously valid: channel 1 follows channel 0, then alternate
        expect_frame(8, PORT_BASE + 16'd1, 8'h80);
        expect_frame(8, PORT_BASE, 8'h40);
        expect_frame(8, PORT_BASE + 16'd1, 8'h88);
        expect_frame(8, PORT_BASE, 8'h48);
        fork
            begin send_beats(0, 1, 8'hFF, 8'h40, 1); send_beats(0, 1, 8'hFF, 8'h48, 1); end
            begin send_beats(1, 1, 8'hFF, 8'h80, 1); send_beats(1, 1, 8'hFF, 8'h88, 1); end
        join
        wait_idle();

        // Payload ready toggling every cycle
        pay_toggle = 1'b1;
        expect_frame(8, PORT_BASE, 8'hA0);
        send_beats(0, 1, 8'hFF, 8'hA0, 1);
        wait_idle();
        pay_toggle = 1'b0;
        check("drops_none", drop_count, 16'd0);

        // 185 full beats = 1480 bytes: overflow on the tlast beat
        send_beats(0, 185, 8'hFF, 8'h00, 185);
        wait_idle();
        check("drop1_count", drop_count, 16'd1);
        check("drop1_pulses", 32'(pulses), 32'd1);
        expect_frame(10, PORT_BASE + 16'd1, 8'h30);
        send_beats(1, 2, 8'h03, 8'h30, 2);
        wait_idle();

        // 190 beats: overflow mid-frame, remaining beats swallowed
        send_beats(0, 190, 8'hFF, 8'h00, 190);
        wait_idle();
        check("drop2_count", drop_count, 16'd2);
        check("drop2_state", dbg_state, 3'd0);

        // Empty frame
        send_beats(1, 1, 8'h00, 8'h00, 1);
        wait_idle();
        check("drop3_count", drop_count, 16'd3);
        check("drop3_pulses", 32'(pulses), 32'd3);

        // Reset in the middle of a frame
        send_beats(0, 5, 8'hFF, 8'h10, 2);
        check("mid_busy", busy, 1'b1);
        rst = 1'b1;
        ch_valid[0] = 1'b0;
        @(negedge clk);
        check("mid_rst_ready", {30'd0, s_axis_tready}, 32'd0);
        check("mid_rst_out", {m_udp_hdr_valid, m_udp_payload_axis_tvalid, m_udp_payload_axis_tlast,
                              busy, drop_pulse}, 5'd0);
        check("mid_rst_drop_count", drop_count, 16'd0);
        rst = 1'b0;
        @(negedge clk);
        expect_frame(8, PORT_BASE, 8'hC0);
        send_beats(0, 1, 8'hFF, 8'hC0, 1);
        wait_idle();

        check("hdr_q_drained", 32'(exp_hdr_q.size()), 32'd0);
        check("byte_q_drained", 32'(exp_byte_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
